capture_ctrl_mc: RTL and testbench

Parametrised successor to the scope's capture/dump controller. It writes NUM_CH sample channels into a circular sample RAM. Pre-trigger depth is programmable, and trigger qualification is gated by an armed condition. After capture it streams any chosen channel back out one byte at a time, using a send/done handshake with the UART transmitter. It sits between the trigger logic, the sample RAMs and the command/UART path.

---
 rtl/capture_ctrl_mc.sv | 209 ++++++++++++++++++++
 tb/tb_capture_ctrl_mc.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl_mc.sv
// rtl/capture_ctrl_mc.sv - circular multi-channel capture controller with byte-wise channel dump
// Optional DECIMATE_EN: adds decimator[3:0] and a prescaler so samples are taken every 2**decimator clocks.
module capture_ctrl_mc #(
  parameter int AW     = 9,
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     trigger,
  input  logic [AW-1:0]            trig_pos,
  output logic                     en,
  output logic                     we,
  output logic [AW-1:0]            addr,
  input  logic [NUM_CH*DATA_W-1:0] ram_rdata,
  input  logic                     start_dump,
  input  logic [CH_W-1:0]          dump_channel,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     send_dump,
  input  logic                     tx_done,
  output logic                     dump_finished,
  output logic                     armed,
  output logic                     capture_done
`ifdef DECIMATE_EN
  ,
  input  logic [3:0]               decimator
`endif
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, PRE, POST, DONE, RD, LAT, SEND, WAIT} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW:0]         fill_q, fill_d;
  logic [AW-1:0]       post_len_q, post_len_d;
  logic [AW-1:0]       post_cnt_q, post_cnt_d;
  logic [AW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                armed_q, armed_d;
  logic                cap_done_q, cap_done_d;
  logic                dump_fin_q, dump_fin_d;
  logic                smp;
  logic [DATA_W-1:0]   sel_byte;
  logic [AW:0]         arm_thresh;

`ifdef DECIMATE_EN
  logic [15:0] presc_q, presc_d;
  logic [15:0] presc_mask;
  assign presc_mask = (16'd1 << decimator) - 16'd1;
  assign smp = (presc_q & presc_mask) == 16'd0;
`else
  assign smp = 1'b1;
`endif

  // Out-of-range channel numbers fall back to channel 0.
  always_comb begin
    sel_byte = ram_rdata[DATA_W-1:0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) sel_byte = ram_rdata[k*DATA_W +: DATA_W];
    end
  end

  assign arm_thresh = DEPTH_W - {1'b0, post_len_q};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fill_d      = fill_q;
    post_len_d  = post_len_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    ch_d        = ch_q;
    dump_data_d = dump_data_q;
    armed_d     = armed_q;
    cap_done_d  = cap_done_q;
    dump_fin_d  = 1'b0;
`ifdef DECIMATE_EN
    presc_d     = presc_q + 16'd1;
`endif
    en          = 1'b0;
    we          = 1'b0;
    addr        = addr_q;
    send_dump   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (run) begin
          state_d    = PRE;
          addr_d     = '0;
          fill_d     = '0;
          cap_done_d = 1'b0;
          armed_d    = 1'b0;
          post_len_d = trig_pos;
`ifdef DECIMATE_EN
          presc_d    = 16'd0;
`endif
        end else if (state_q == DONE && start_dump) begin
          state_d  = RD;
          ch_d     = dump_channel;
          rd_cnt_d = '0;
        end
      end
      PRE: begin
        armed_d = fill_q >= arm_thresh;
        if (smp) begin
          en     = 1'b1;
          we     = 1'b1;
          addr_d = addr_q + 1'b1;
          if (fill_q != DEPTH_W) fill_d = fill_q + (AW+1)'(1);
          // The registered armed flag gates the trigger, so a trigger coincident with arming is dropped.
          if (armed_q && trigger) begin
            post_cnt_d = post_len_q;
            armed_d    = 1'b0;
            if (post_len_q == '0) begin
              state_d    = DONE;
              cap_done_d = 1'b1;
            end else begin
              state_d = POST;
            end
          end
        end
      end
      POST: begin
        if (smp) begin
          en         = 1'b1;
          we         = 1'b1;
          addr_d     = addr_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == AW'(1)) begin
            state_d    = DONE;
            cap_done_d = 1'b1;
          end
        end
      end
      RD: begin
        // addr_q holds the oldest sample for the whole dump.
        en      = 1'b1;
        addr    = addr_q + rd_cnt_q;
        state_d = LAT;
      end
      LAT: begin
        dump_data_d = sel_byte;
        state_d     = SEND;
      end
      SEND: begin
        send_dump = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (rd_cnt_q == {AW{1'b1}}) begin
            dump_fin_d = 1'b1;
            state_d    = DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            state_d  = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      fill_q      <= '0;
      post_len_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      ch_q        <= '0;
      dump_data_q <= '0;
      armed_q     <= 1'b0;
      cap_done_q  <= 1'b0;
      dump_fin_q  <= 1'b0;
`ifdef DECIMATE_EN
      presc_q     <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fill_q      <= fill_d;
      post_len_q  <= post_len_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      ch_q        <= ch_d;
      dump_data_q <= dump_data_d;
      armed_q     <= armed_d;
      cap_done_q  <= cap_done_d;
      dump_fin_q  <= dump_fin_d;
`ifdef DECIMATE_EN
      presc_q     <= presc_d;
`endif
    end
  end

  assign dump_data     = dump_data_q;
  assign dump_finished = dump_fin_q;
  assign armed         = armed_q;
  assign capture_done  = cap_done_q;

endmodule

// File: tb/tb_capture_ctrl_mc.sv
// tb/tb_capture_ctrl_mc.sv - scoreboard bench for capture_ctrl_mc (default build)
module tb_capture_ctrl_mc;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, trigger = 1'b0, start_dump = 1'b0, tx_done = 1'b0;
  logic [8:0]  trig_pos = '0;
  logic [1:0]  dump_channel = '0;
  logic        en, we, send_dump, dump_finished, armed, capture_done;
  logic [8:0]  addr;
  logic [7:0]  dump_data;
  logic [31:0] rdata = '0;

  capture_ctrl_mc dut (
    .clk(clk), .rst_n(rst_n), .run(run), .trigger(trigger), .trig_pos(trig_pos),
    .en(en), .we(we), .addr(addr), .ram_rdata(rdata), .start_dump(start_dump),
    .dump_channel(dump_channel), .dump_data(dump_data), .send_dump(send_dump),
    .tx_done(tx_done), .dump_finished(dump_finished), .armed(armed),
    .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int sends = 0, fins = 0, seq = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] hist [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_byte = '0, exp_b;
  bit          addr_mode = 0;
  logic [8:0]  addr_base = '0;

  function automatic logic [31:0] wval(int s, logic [8:0] a);
    logic [31:0] w;
    w[7:0]   = 8'(s);
    w[15:8]  = 8'(s * 3 + 17);
    w[23:16] = a[7:0];
    w[31:24] = 8'(s * 7 + 99);
    return w;
  endfunction

  // Sample RAM: synchronous write, registered read one cycle after en.
  always @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wval(seq, addr);
      hist.push_back(wval(seq, addr));
      seq <= seq + 1;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

  always @(negedge clk) begin
    if (rst_n && send_dump) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: dump_data=%0h sent with no expected byte", dump_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (dump_data !== exp_b) begin
          miscompares++;
          $display("FAIL sb_byte%0d: got %0h expected %0h", sends, dump_data, exp_b);
        end
      end
      if (addr_mode) begin
        vectors++;
        if (dump_data !== 8'(addr_base + 9'(sends))) begin
          miscompares++;
          $display("FAIL ch2_addr_byte%0d: got %0h expected %0h", sends, dump_data, 8'(addr_base + 9'(sends)));
        end
      end
      last_byte = dump_data;
      sends++;
    end
    if (rst_n && dump_finished) fins++;
  end

  task automatic run_capture(input logic [8:0] tp, output int wr);
    @(negedge clk);
    trig_pos = tp;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wr = (en && we) ? 1 : 0;
  endtask

  task automatic wait_armed(inout int wr, output bit to);
    int cyc = 0;
    while (!armed && cyc < 2000) begin
      @(negedge clk);
      if (en && we) wr++;
      cyc++;
    end
    to = !armed;
  endtask

  task automatic count_post(output int post, output bit wrapped);
    int cyc = 0;
    logic [8:0] prev = addr;
    post = 0;
    wrapped = 0;
    while (!capture_done && cyc < 2000) begin
      if (en && we) begin
        post++;
        if (prev == 9'd511 && addr == 9'd0) wrapped = 1;
        prev = addr;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_dump(input logic [1:0] ch, input int nbytes, output bit to);
    int n_hist = hist.size();
    int cyc;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(hist[n_hist - DEPTH + i][8*ch +: 8]);
    @(negedge clk);
    sends = 0;
    fins = 0;
    start_dump = 1'b1;
    dump_channel = ch;
    @(negedge clk);
    start_dump = 1'b0;
    to = 0;
    for (int n = 0; n < nbytes; n++) begin
      cyc = 0;
      while (!send_dump && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      if (!send_dump) begin
        to = 1;
        break;
      end
      repeat (2) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic test_reset;
    int en_seen = 0;
    vectors++;
    if ({en, we, send_dump, dump_finished, armed, capture_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000", {en, we, send_dump, dump_finished, armed, capture_done});
    end
    vectors++;
    if (addr !== 9'd0 || dump_data !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_addr_data: addr=%0d data=%0h expected 0 0", addr, dump_data);
    end
    start_dump = 1'b1;
    @(negedge clk);
    start_dump = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (en || send_dump) en_seen++;
    end
    vectors++;
    if (en_seen !== 0) begin
      miscompares++;
      $display("FAIL idle_start_dump: %0d active cycles expected 0", en_seen);
    end
  endtask

  task automatic test_arm_trigger;
    int wr, post;
    bit to, wrapped;
    run_capture(9'd256, wr);
    while (wr < 100) begin
      @(negedge clk);
      if (en && we) wr++;
    end
    vectors++;
    if (armed !== 1'b0) begin
      miscompares++;
      $display("FAIL early_armed: got %b expected 0", armed);
    end
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    if (en && we) wr++;
    wait_armed(wr, to);
    vectors++;
    if (to || wr != 258) begin
      miscompares++;
      $display("FAIL arm_point: armed at write %0d (timeout %0d) expected 258", wr, to);
    end
    vectors++;
    if (capture_done !== 1'b0) begin
      miscompares++;
      $display("FAIL early_trigger_ignored: capture_done=%b expected 0", capture_done);
    end
    repeat (10) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    count_post(post, wrapped);
    vectors++;
    if (post != 256) begin
      miscompares++;
      $display("FAIL post_writes256: got %0d expected 256", post);
    end
    vectors++;
    if ({capture_done, armed, en, we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL done_flags: got %b expected 1000", {capture_done, armed, en, we});
    end
  endtask

  task automatic test_trig0;
    int wr, trig_idx;
    bit to;
    run_capture(9'd0, wr);
    wait_armed(wr, to);
    vectors++;
    if (to || wr != DEPTH + 2) begin
      miscompares++;
      $display("FAIL arm_point0: armed at write %0d expected %0d", wr, DEPTH + 2);
    end
    trig_idx = hist.size();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    vectors++;
    if (capture_done !== 1'b1 || en !== 1'b0) begin
      miscompares++;
      $display("FAIL trig0_done: capture_done=%b en=%b expected 1 0", capture_done, en);
    end
    do_dump(2'd1, DEPTH, to);
    repeat (3) @(negedge clk);
    vectors++;
    if (to || sends != DEPTH || fins != 1) begin
      miscompares++;
      $display("FAIL trig0_dump: sends=%0d fins=%0d to=%0d expected %0d 1 0", sends, fins, to, DEPTH);
    end
    vectors++;
    if (last_byte !== hist[trig_idx][15:8]) begin
      miscompares++;
      $display("FAIL trig0_last_byte: got %0h expected %0h", last_byte, hist[trig_idx][15:8]);
    end
  endtask

  task automatic test_trig511_dump;
    int wr, post;
    bit to, wrapped;
    logic [8:0] exp_start;
    run_capture(9'd511, wr);
    wait_armed(wr, to);
    vectors++;
    if (to || wr != 3) begin
      miscompares++;
      $display("FAIL arm_point511: armed at write %0d expected 3", wr);
    end
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    count_post(post, wrapped);
    exp_start = 9'(wr + post);
    vectors++;
    if (post != 511 || !wrapped) begin
      miscompares++;
      $display("FAIL post511: writes=%0d wrapped=%0d expected 511 1", post, wrapped);
    end
    vectors++;
    if (addr !== exp_start) begin
      miscompares++;
      $display("FAIL start_addr: got %0d expected %0d", addr, exp_start);
    end
    addr_base = exp_start;
    addr_mode = 1;
    do_dump(2'd2, DEPTH, to);
    repeat (3) @(negedge clk);
    addr_mode = 0;
    vectors++;
    if (to || sends != DEPTH || fins != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL dump_ch2: sends=%0d fins=%0d left=%0d expected %0d 1 0", sends, fins, exp_q.size(), DEPTH);
    end
    vectors++;
    if (capture_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_after_dump: got %b expected 1", capture_done);
    end
    do_dump(2'd0, DEPTH, to);
    repeat (3) @(negedge clk);
    vectors++;
    if (to || sends != DEPTH || fins != 1) begin
      miscompares++;
      $display("FAIL dump_ch0_again: sends=%0d fins=%0d expected %0d 1", sends, fins, DEPTH);
    end
  endtask

  task automatic test_reset_mid_dump;
    bit to;
    int cyc = 0;
    int sends_at_rst;
    do_dump(2'd3, 37, to);
    while (!send_dump && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sends_at_rst = sends;
    vectors++;
    if ({en, we, send_dump, dump_finished, armed, capture_done} !== 6'b0 || addr !== 9'd0 || dump_data !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: flags=%b addr=%0d data=%0h expected all 0",
               {en, we, send_dump, dump_finished, armed, capture_done}, addr, dump_data);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (to || sends_at_rst != 38 || sends != 38 || fins != 0) begin
      miscompares++;
      $display("FAIL after_reset_quiet: sends=%0d/%0d fins=%0d expected 38/38 0", sends_at_rst, sends, fins);
    end
  endtask

  task automatic test_run_wins;
    int wr, post;
    bit to, wrapped;
    run_capture(9'd0, wr);
    wait_armed(wr, to);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    sends = 0;
    run = 1'b1;
    start_dump = 1'b1;
    dump_channel = 2'd1;
    trig_pos = 9'd4;
    @(negedge clk);
    run = 1'b0;
    start_dump = 1'b0;
    vectors++;
    if ({en, we, capture_done} !== 3'b110) begin
      miscompares++;
      $display("FAIL run_wins: en/we/done=%b expected 110", {en, we, capture_done});
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (sends != 0 || armed !== 1'b0) begin
      miscompares++;
      $display("FAIL run_wins_quiet: sends=%0d armed=%b expected 0 0", sends, armed);
    end
    wr = 9;
    wait_armed(wr, to);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    count_post(post, wrapped);
    vectors++;
    if (to || post != 4) begin
      miscompares++;
      $display("FAIL rearm_post4: writes=%0d expected 4", post);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_arm_trigger();
    test_trig0();
    test_trig511_dump();
    test_reset_mid_dump();
    test_run_wins();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
